// File: rtl/readout_rx_demod_unit.sv
// Readout receive demodulator: mixes signed ADC samples with an NCO sin/cos
// reference and integrates I/Q over a programmable window, one result per window.
module readout_rx_demod_unit #(
    parameter int NCO_N          = 22,
    parameter int PHASE_WIDTH    = 10,
    parameter int LUT_DATA_WIDTH = 16,
    parameter int ADC_WIDTH      = 8,
    parameter int ACC_WIDTH      = 40,
    parameter int WIN_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      nco_ftw_wr_en,
    input  logic [NCO_N-1:0]          nco_ftw_in,
    input  logic                      win_len_wr_en,
    input  logic [WIN_WIDTH-1:0]      win_len_in,
    input  logic                      start_in,
    input  logic                      valid_adc_in,
    input  logic [ADC_WIDTH-1:0]      adc_data_in,
    output logic [PHASE_WIDTH-1:0]    sin_lut_rd_addr_out,
    input  logic [LUT_DATA_WIDTH-1:0] sin_lut_rd_data_in,
    output logic [PHASE_WIDTH-1:0]    cos_lut_rd_addr_out,
    input  logic [LUT_DATA_WIDTH-1:0] cos_lut_rd_data_in,
    output logic                      busy_out,
    output logic                      valid_iq_out,
    output logic [ACC_WIDTH-1:0]      i_out,
    output logic [ACC_WIDTH-1:0]      q_out
);

    localparam int PROD_WIDTH = ADC_WIDTH + LUT_DATA_WIDTH;
    localparam logic [PHASE_WIDTH-1:0] QUARTER_TURN = PHASE_WIDTH'(2 ** (PHASE_WIDTH - 2));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [NCO_N-1:0]       ftw;
    logic [NCO_N-1:0]       phase_acc;
    logic [WIN_WIDTH-1:0]   win_len;
    logic [WIN_WIDTH-1:0]   win_len_snap;
    logic [WIN_WIDTH-1:0]   sample_cnt;
    logic                   drain_cnt;
    logic                   accept;
    logic                   start_go;
    logic                   last_sample;
    logic                   drain_done;
    logic                   s1_valid;
    logic                   s2_valid;
    logic signed [ADC_WIDTH-1:0]      s1_adc;
    logic [PHASE_WIDTH-1:0]           sin_addr;
    logic [PHASE_WIDTH-1:0]           cos_addr;
    logic [PHASE_WIDTH-1:0]           phase_addr;
    logic signed [LUT_DATA_WIDTH-1:0] sin_data;
    logic signed [LUT_DATA_WIDTH-1:0] cos_data;
    logic signed [PROD_WIDTH-1:0]     i_prod;
    logic signed [PROD_WIDTH-1:0]     q_prod;
    logic signed [ACC_WIDTH-1:0]      i_acc;
    logic signed [ACC_WIDTH-1:0]      q_acc;
    logic                             valid_iq;

    assign phase_addr = phase_acc[NCO_N-1 -: PHASE_WIDTH];
    assign sin_data   = $signed(sin_lut_rd_data_in);
    assign cos_data   = $signed(cos_lut_rd_data_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_go)    state_next = RUN;
            RUN:     if (last_sample) state_next = DRAIN;
            DRAIN:   if (drain_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept      = (state == RUN) && valid_adc_in;
        start_go    = (state == IDLE) && start_in && (win_len != '0);
        last_sample = accept && (sample_cnt == win_len_snap - WIN_WIDTH'(1));
        drain_done  = (state == DRAIN) && drain_cnt;
        busy_out    = (state != IDLE);
    end

    // Three-stage datapath: address/sample capture, product, accumulate.
    // Only accepted samples move through, so input gaps never change the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ftw          <= '0;
            win_len      <= '0;
            win_len_snap <= '0;
            sample_cnt   <= '0;
            phase_acc    <= '0;
            drain_cnt    <= 1'b0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s1_adc       <= '0;
            sin_addr     <= '0;
            cos_addr     <= '0;
            i_prod       <= '0;
            q_prod       <= '0;
            i_acc        <= '0;
            q_acc        <= '0;
            valid_iq     <= 1'b0;
        end else begin
            if (nco_ftw_wr_en) ftw <= nco_ftw_in;
            if (win_len_wr_en) win_len <= win_len_in;

            valid_iq  <= drain_done;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            s1_valid  <= accept;
            s2_valid  <= s1_valid;

            if (accept) begin
                s1_adc     <= $signed(adc_data_in);
                sin_addr   <= phase_addr;
                cos_addr   <= phase_addr + QUARTER_TURN;
                sample_cnt <= sample_cnt + WIN_WIDTH'(1);
                phase_acc  <= phase_acc + ftw;
            end

            if (s1_valid) begin
                i_prod <= PROD_WIDTH'(s1_adc) * PROD_WIDTH'(cos_data);
                q_prod <= PROD_WIDTH'(s1_adc) * PROD_WIDTH'(sin_data);
            end

            if (start_go) begin
                win_len_snap <= win_len;
                sample_cnt   <= '0;
                phase_acc    <= '0;
                i_acc        <= '0;
                q_acc        <= '0;
            end else if (s2_valid) begin
                i_acc <= i_acc + ACC_WIDTH'(i_prod);
                q_acc <= q_acc + ACC_WIDTH'(q_prod);
            end
        end
    end

    assign sin_lut_rd_addr_out = sin_addr;
    assign cos_lut_rd_addr_out = cos_addr;
    assign valid_iq_out        = valid_iq;
    assign i_out               = i_acc;
    assign q_out               = q_acc;

endmodule
